gp_register_file: RTL and testbench

- Parametrised general-purpose register file for the CPU datapath; successor to the single-accumulator register.
- Holds NUM_REGS registers of DATA_W bits. Provides two combinational read ports and one command-qualified write port.
- Writes go through a one-entry staging pipeline with read bypass.
- A per-register busy scoreboard lets the control unit reserve a destination at decode and have it released at write-back commit.

---
 rtl/gp_regfile_pkg.sv | 17 +
 rtl/gp_regfile_scoreboard.sv | 36 +++
 rtl/gp_register_file.sv | 125 ++++++++++++
 tb/tb_gp_register_file.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gp_regfile_pkg.sv
// Shared constants and types for the general-purpose register file.
package gp_regfile_pkg;

  localparam logic [3:0]  WR_CMD_WRITE    = 4'h3;
  localparam logic [3:0]  WR_CMD_NOP      = 4'h0;
  localparam logic [31:0] REG_RESET_DEBUG = 32'h0000_0999;
  localparam int unsigned NUM_REGS_DEF    = 8;
  localparam int unsigned ADDR_W_DEF      = 4;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  // True when a (zero-extended) register address names an implemented register.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/gp_regfile_scoreboard.sv
// Per-register busy scoreboard: reserve sets a bit, commit clears it, reserve wins a tie.
module gp_regfile_scoreboard
  import gp_regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic                clock_4,
  input  logic                reset,
  input  logic                set_valid,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_valid,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear first, then set, so a same-edge reserve keeps the bit high.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (clr_valid && (clr_addr == ADDR_W'(i))) busy_d[i] = 1'b0;
      if (set_valid && (set_addr == ADDR_W'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clock_4 or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/gp_register_file.sv
// General-purpose register file: two bypassed read ports, staged write port, busy scoreboard.
// Define GP_REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module gp_register_file
  import gp_regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter logic [31:0] RESET_VAL = REG_RESET_DEBUG,
  parameter logic [3:0]  WR_CMD    = WR_CMD_WRITE
) (
  input  logic                clock_4,
  input  logic                reset,
  input  logic [3:0]          wr_cmd,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]   rd_data_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_b,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                stg_valid,
  output logic                addr_err
);

`ifdef GP_REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  localparam logic [DATA_W-1:0] RST_VAL = DATA_W'(RESET_VAL);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              stg_valid_q, stg_valid_d;
  logic [ADDR_W-1:0] stg_addr_q,  stg_addr_d;
  logic [DATA_W-1:0] stg_data_q,  stg_data_d;
  logic              addr_err_q,  addr_err_d;
  logic              wr_req;
  logic              wr_in_range;
  logic              rsv_in_range;
  logic              rsv_set;

  // Request qualification; out-of-range requests are dropped and flagged.
  always_comb begin
    wr_req       = (wr_cmd == WR_CMD);
    wr_in_range  = addr_in_range(32'(wr_addr), NUM_REGS);
    rsv_in_range = addr_in_range(32'(rsv_addr), NUM_REGS);
    rsv_set      = rsv_valid && rsv_in_range && !(ZERO_REG_EN && (rsv_addr == '0));
    addr_err_d   = (wr_req && !wr_in_range) || (rsv_valid && !rsv_in_range);
  end

  // Staging entry is rewritten every edge; address/data hold when idle.
  always_comb begin
    stg_valid_d = wr_req && wr_in_range;
    stg_addr_d  = stg_addr_q;
    stg_data_d  = stg_data_q;
    if (stg_valid_d) begin
      stg_addr_d = wr_addr;
      stg_data_d = wr_data;
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (stg_valid_q && (stg_addr_q == ADDR_W'(i)) && !(ZERO_REG_EN && (i == 0)))
        regs_d[i] = stg_data_q;
    end
  end

  always_ff @(posedge clock_4 or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (ZERO_REG_EN && (i == 0)) ? '0 : RST_VAL;
      stg_valid_q <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Read port A: array, then staging bypass, then zero-register override.
  always_comb begin
    rd_data_a = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (rd_addr_a == ADDR_W'(i)) rd_data_a = regs_q[i];
    if (stg_valid_q && (stg_addr_q == rd_addr_a)) rd_data_a = stg_data_q;
    if (ZERO_REG_EN && (rd_addr_a == '0)) rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (rd_addr_b == ADDR_W'(i)) rd_data_b = regs_q[i];
    if (stg_valid_q && (stg_addr_q == rd_addr_b)) rd_data_b = stg_data_q;
    if (ZERO_REG_EN && (rd_addr_b == '0)) rd_data_b = '0;
  end

  gp_regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clock_4   (clock_4),
    .reset     (reset),
    .set_valid (rsv_set),
    .set_addr  (rsv_addr),
    .clr_valid (stg_valid_q),
    .clr_addr  (stg_addr_q),
    .busy      (busy)
  );

  assign stg_valid = stg_valid_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_gp_register_file.sv
// Directed bench for gp_register_file; honours GP_REGFILE_ZERO_REG_EN when defined.
module tb_gp_register_file;

  logic        clock_4;
  logic        reset;
  logic [3:0]  wr_cmd;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic        rsv_valid;
  logic [3:0]  rsv_addr;
  logic [7:0]  busy;
  logic        stg_valid;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  gp_register_file dut (
    .clock_4   (clock_4),
    .reset     (reset),
    .wr_cmd    (wr_cmd),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .busy      (busy),
    .stg_valid (stg_valid),
    .addr_err  (addr_err)
  );

  initial clock_4 = 1'b0;
  always #5 clock_4 = ~clock_4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; sampling happens on the falling edge.
  task automatic cyc();
    @(negedge clock_4);
  endtask

  initial begin
    logic [31:0] r0_rst;
    logic [31:0] r0_wr;
    logic [7:0]  busy_r0;
`ifdef GP_REGFILE_ZERO_REG_EN
    r0_rst  = 32'h0;
    r0_wr   = 32'h0;
    busy_r0 = 8'h00;
`else
    r0_rst  = 32'h999;
    r0_wr   = 32'h77;
    busy_r0 = 8'h01;
`endif

    reset = 1'b1; wr_cmd = 4'h0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; rsv_valid = 1'b0; rsv_addr = '0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // Reset state of every register on both ports.
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(7 - i); #1;
      chk("rst_rd_a", rd_data_a, (i == 0) ? r0_rst : 32'h999);
      chk("rst_rd_b", rd_data_b, (i == 7) ? r0_rst : 32'h999);
    end
    rd_addr_a = 4'd9; #1;
    chk("rst_rd_oob", rd_data_a, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_stg", 32'(stg_valid), 32'h0);
    chk("rst_err", 32'(addr_err), 32'h0);

    // Single write with bypass then array read.
    wr_cmd = 4'h3; wr_addr = 4'd2; wr_data = 32'hDEADBEEF; rd_addr_a = 4'd2; #1;
    chk("wr2_pre", rd_data_a, 32'h999);
    cyc();
    chk("wr2_byp", rd_data_a, 32'hDEADBEEF);
    chk("wr2_stg", 32'(stg_valid), 32'h1);
    wr_cmd = 4'h0;
    cyc();
    chk("wr2_arr", rd_data_a, 32'hDEADBEEF);
    chk("wr2_stg0", 32'(stg_valid), 32'h0);
    chk("wr2_busy", 32'(busy), 32'h0);

    // Back-to-back writes to register 5.
    wr_cmd = 4'h3; wr_addr = 4'd5; wr_data = 32'h11; rd_addr_a = 4'd5; rd_addr_b = 4'd4;
    cyc();
    chk("b2b_a1", rd_data_a, 32'h11);
    chk("b2b_b1", rd_data_b, 32'h999);
    wr_data = 32'h22;
    cyc();
    chk("b2b_a2", rd_data_a, 32'h22);
    chk("b2b_stg", 32'(stg_valid), 32'h1);
    wr_cmd = 4'h0;
    cyc();
    chk("b2b_a3", rd_data_a, 32'h22);
    chk("b2b_b3", rd_data_b, 32'h999);

    // Scoreboard reserve / commit / tie.
    rsv_valid = 1'b1; rsv_addr = 4'd3;
    cyc();
    chk("sb_rsv", 32'(busy), 32'h08);
    rsv_valid = 1'b0; wr_cmd = 4'h3; wr_addr = 4'd3; wr_data = 32'h33;
    cyc();
    chk("sb_stage", 32'(busy), 32'h08);
    wr_cmd = 4'h0;
    cyc();
    chk("sb_commit", 32'(busy), 32'h00);
    wr_cmd = 4'h3; wr_data = 32'h44;
    cyc();
    wr_cmd = 4'h0; rsv_valid = 1'b1; rsv_addr = 4'd3;
    cyc();
    chk("sb_tie", 32'(busy), 32'h08);
    rsv_addr = 4'd3;
    cyc();
    chk("sb_rersv", 32'(busy), 32'h08);
    rsv_addr = 4'd6; wr_cmd = 4'h3; wr_addr = 4'd3; wr_data = 32'h45;
    cyc();
    chk("sb_two", 32'(busy), 32'h48);
    rsv_valid = 1'b0; wr_addr = 4'd6; wr_data = 32'h66;
    cyc();
    chk("sb_rel3", 32'(busy), 32'h40);
    wr_cmd = 4'h0; rd_addr_a = 4'd3; rd_addr_b = 4'd6;
    cyc();
    chk("sb_rel6", 32'(busy), 32'h00);
    chk("sb_r3", rd_data_a, 32'h45);
    chk("sb_r6", rd_data_b, 32'h66);

    // Out-of-range write and reserve.
    wr_cmd = 4'h3; wr_addr = 4'd9; wr_data = 32'h99; rd_addr_a = 4'd5;
    cyc();
    chk("err_wr", 32'(addr_err), 32'h1);
    chk("err_wr_stg", 32'(stg_valid), 32'h0);
    chk("err_wr_r5", rd_data_a, 32'h22);
    wr_cmd = 4'h0;
    cyc();
    chk("err_pulse", 32'(addr_err), 32'h0);
    rsv_valid = 1'b1; rsv_addr = 4'd8;
    cyc();
    chk("err_rsv", 32'(addr_err), 32'h1);
    chk("err_rsv_busy", 32'(busy), 32'h0);
    rsv_valid = 1'b0; wr_cmd = 4'h5; wr_addr = 4'd9;
    cyc();
    chk("err_nocmd", 32'(addr_err), 32'h0);
    wr_cmd = 4'h0;

    // Reset between stage and commit.
    wr_cmd = 4'h3; wr_addr = 4'd1; wr_data = 32'h55; rsv_valid = 1'b1; rsv_addr = 4'd4;
    rd_addr_a = 4'd1; rd_addr_b = 4'd5;
    cyc();
    chk("mid_stg", 32'(stg_valid), 32'h1);
    chk("mid_busy", 32'(busy), 32'h10);
    chk("mid_byp", rd_data_a, 32'h55);
    wr_cmd = 4'h0; rsv_valid = 1'b0;
    reset = 1'b1; #1;
    chk("mid_rst_stg", 32'(stg_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_r1", rd_data_a, 32'h999);
    chk("mid_rst_r5", rd_data_b, 32'h999);
    cyc();
    reset = 1'b0;
    cyc();
    chk("mid_after_r1", rd_data_a, 32'h999);

    // Register 0: ordinary, or hardwired zero when the feature is built in.
    wr_cmd = 4'h3; wr_addr = 4'd0; wr_data = 32'h77; rsv_valid = 1'b1; rsv_addr = 4'd0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    cyc();
    chk("z_stg", 32'(stg_valid), 32'h1);
    chk("z_byp", rd_data_a, r0_wr);
    chk("z_busy", 32'(busy), 32'(busy_r0));
    chk("z_err", 32'(addr_err), 32'h0);
    wr_cmd = 4'h0; rsv_valid = 1'b0;
    cyc();
    chk("z_arr", rd_data_b, r0_wr);
    chk("z_busy_clr", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
